attex_bus_ctrl: RTL and testbench

- Central bus controller for the CD-i system bus, sitting between the scc68070 master and the on-board slaves: mcd212 (including its ROM window), cdic, 68HC05 slave port and nvram.
- Decodes each CPU cycle into one region and drives exactly one registered chip select.
- Sequences the acknowledge (fixed wait states, device ack, or slave DTACK edge), registers the read data, and raises bus error on forbidden or timed-out accesses.
- Generates the delayed slave-interrupt pulse toward the 68HC05.

---
 rtl/attex_pkg.sv | 51 +++++
 rtl/attex_bus_ctrl_if.sv | 37 +++
 rtl/attex_slave_irq_timer.sv | 23 ++
 rtl/attex_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_attex_bus_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/attex_pkg.sv
// Shared types, address map and region decoder for the CD-i system bus controller.
// Also reused by the bench to classify addresses.
package attex_pkg;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MCD,
        REG_CDIC,
        REG_SLAVE,
        REG_NVRAM,
        REG_ERR
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERROR
    } state_e;

    localparam logic [23:0] MCD_LO_LIMIT = 24'h27FFFF;
    localparam logic [23:0] MCD_HI_BASE  = 24'h400000;
    localparam logic [23:0] MCD_HI_LIMIT = 24'h5FFFFF;
    localparam logic [23:0] ERR_LO_BASE  = 24'h600000;
    localparam logic [23:0] ERR_LO_LIMIT = 24'hCFFFFF;
    localparam logic [23:0] ERR_HI_BASE  = 24'hF00000;
    localparam logic [7:0]  CDIC_PAGE    = 8'h30;
    localparam logic [7:0]  SLAVE_PAGE   = 8'h31;
    localparam logic [7:0]  NVRAM_PAGE   = 8'h32;

    // Takes the CPU word address; checks run in priority order, ERR first.
    function automatic region_e decode_region(input logic [22:0] addr);
        logic [23:0] a;
        region_e     r;
        a = {addr, 1'b0};
        if ((a >= ERR_LO_BASE && a <= ERR_LO_LIMIT) || a >= ERR_HI_BASE)
            r = REG_ERR;
        else if (a[23:16] == CDIC_PAGE)
            r = REG_CDIC;
        else if (a[23:16] == SLAVE_PAGE)
            r = REG_SLAVE;
        else if (a[23:16] == NVRAM_PAGE)
            r = REG_NVRAM;
        else if (a <= MCD_LO_LIMIT || (a >= MCD_HI_BASE && a <= MCD_HI_LIMIT))
            r = REG_MCD;
        else
            r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/attex_bus_ctrl_if.sv
// CPU-side and device-side bus signals of the controller.
// slave modport is the controller's view; master is the CPU/device environment.
interface attex_bus_ctrl_if;
    logic        as;
    logic        uds;
    logic        lds;
    logic        write_strobe;
    logic [22:0] addr;
    logic [15:0] data_in;
    logic        bus_ack;
    logic        bus_err;
    logic        cs_mcd212;
    logic        cs_cdic;
    logic        cs_slave;
    logic        cs_nvram;
    logic [15:0] mcd212_dout;
    logic        mcd212_bus_ack;
    logic [15:0] cdic_dout;
    logic [15:0] slave_dout;
    logic        dtackslaven;
    logic [7:0]  nvram_dout;
    logic        slave_irq;

    modport slave (
        input  as, uds, lds, write_strobe, addr,
        input  mcd212_dout, mcd212_bus_ack, cdic_dout, slave_dout, dtackslaven, nvram_dout,
        output data_in, bus_ack, bus_err,
        output cs_mcd212, cs_cdic, cs_slave, cs_nvram, slave_irq
    );

    modport master (
        output as, uds, lds, write_strobe, addr,
        output mcd212_dout, mcd212_bus_ack, cdic_dout, slave_dout, dtackslaven, nvram_dout,
        input  data_in, bus_ack, bus_err,
        input  cs_mcd212, cs_cdic, cs_slave, cs_nvram, slave_irq
    );
endinterface

// File: rtl/attex_slave_irq_timer.sv
// Delayed one-cycle interrupt pulse toward the 68HC05; a reload restarts the delay.
// Pulse is high while the counter holds 1, i.e. DELAY-1 cycles after the load edge.
module attex_slave_irq_timer #(
    parameter int unsigned DELAY = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    output logic o_irq
);
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= 8'd0;
        else if (i_load)
            r_cnt <= 8'(DELAY);
        else if (r_cnt != 8'd0)
            r_cnt <= r_cnt - 8'd1;
    end

    assign o_irq = (r_cnt == 8'd1);
endmodule

// File: rtl/attex_bus_ctrl.sv
// CD-i bus controller: decodes scc68070 cycles, drives one registered chip select,
// sequences DTACK / bus error, registers read data and launches the slave irq timer.
module attex_bus_ctrl
    import attex_pkg::*;
#(
    parameter int unsigned CDIC_WAIT       = 2,
    parameter int unsigned NVRAM_WAIT      = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter int unsigned SLAVE_IRQ_DELAY = 20
) (
    input  logic             clk,
    input  logic             reset,
    attex_bus_ctrl_if.slave  bus
);
    localparam logic [7:0] LP_CDIC_WAIT  = 8'(CDIC_WAIT);
    localparam logic [7:0] LP_NVRAM_WAIT = 8'(NVRAM_WAIT);
    localparam logic [7:0] LP_TIMEOUT    = 8'(TIMEOUT_CYCLES);

    state_e      r_state;
    state_e      w_state_nxt;
    region_e     r_region;
    region_e     w_region;
    region_e     w_cs_region;
    logic        r_write;
    logic [7:0]  r_cnt;
    logic        r_dtack_q;
    logic [15:0] r_data;
    logic        r_ack;
    logic        r_err;
    logic        r_cs_mcd;
    logic        r_cs_cdic;
    logic        r_cs_slave;
    logic        r_cs_nvram;
    logic        w_start;
    logic        w_done;
    logic        w_dtack_rise;
    logic        w_bus_active;
    logic        w_irq_load;
    logic [15:0] w_rd_mux;

    assign w_start      = bus.as && (bus.uds || bus.lds);
    assign w_region     = decode_region(bus.addr);
    assign w_dtack_rise = bus.dtackslaven && !r_dtack_q;

    // r_cnt counts WAIT cycles including the current one, so it reads 1 on WAIT entry.
    always_comb begin
        w_done = 1'b0;
        case (r_region)
            REG_CDIC:  w_done = (r_cnt == LP_CDIC_WAIT);
            REG_NVRAM: w_done = (r_cnt == LP_NVRAM_WAIT);
            REG_MCD:   w_done = bus.mcd212_bus_ack;
            REG_SLAVE: w_done = w_dtack_rise;
            default:   w_done = 1'b0;
        endcase
    end

    always_comb begin
        w_rd_mux = 16'd0;
        case (r_region)
            REG_CDIC:  w_rd_mux = bus.cdic_dout;
            REG_NVRAM: w_rd_mux = {bus.nvram_dout, bus.nvram_dout};
            REG_MCD:   w_rd_mux = bus.mcd212_dout;
            REG_SLAVE: w_rd_mux = bus.slave_dout;
            default:   w_rd_mux = 16'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start)
                    w_state_nxt = (w_region == REG_ERR) ? ST_ERROR : ST_WAIT;
            end
            ST_WAIT: begin
                if (!w_start)
                    w_state_nxt = ST_IDLE;
                else if (w_done)
                    w_state_nxt = ST_ACK;
                else if (r_cnt == LP_TIMEOUT)
                    w_state_nxt = ST_ERROR;
            end
            ST_ACK: begin
                if (!bus.as)
                    w_state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                if (!bus.as)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Chip selects follow the next state so they appear the cycle after the strobe.
    assign w_cs_region  = (r_state == ST_IDLE) ? w_region : r_region;
    assign w_bus_active = (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_ACK);
    assign w_irq_load   = (r_state == ST_IDLE) && (w_state_nxt == ST_WAIT) &&
                          (w_region == REG_SLAVE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_region   <= REG_NONE;
            r_write    <= 1'b0;
            r_cnt      <= 8'd0;
            r_dtack_q  <= 1'b0;
            r_data     <= 16'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_cs_mcd   <= 1'b0;
            r_cs_cdic  <= 1'b0;
            r_cs_slave <= 1'b0;
            r_cs_nvram <= 1'b0;
        end else begin
            r_dtack_q <= bus.dtackslaven;
            if (r_state == ST_IDLE && w_start) begin
                r_region <= w_region;
                r_write  <= bus.write_strobe;
                r_cnt    <= 8'd1;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == ST_WAIT && w_state_nxt == ST_ACK && !r_write)
                r_data <= w_rd_mux;
            r_ack      <= (w_state_nxt == ST_ACK);
            r_err      <= (w_state_nxt == ST_ERROR);
            r_cs_mcd   <= w_bus_active && (w_cs_region == REG_MCD);
            r_cs_cdic  <= w_bus_active && (w_cs_region == REG_CDIC);
            r_cs_slave <= w_bus_active && (w_cs_region == REG_SLAVE);
            r_cs_nvram <= w_bus_active && (w_cs_region == REG_NVRAM);
        end
    end

    attex_slave_irq_timer #(
        .DELAY (SLAVE_IRQ_DELAY)
    ) u_irq_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_irq_load),
        .o_irq  (bus.slave_irq)
    );

    assign bus.data_in   = r_data;
    assign bus.bus_ack   = r_ack;
    assign bus.bus_err   = r_err;
    assign bus.cs_mcd212 = r_cs_mcd;
    assign bus.cs_cdic   = r_cs_cdic;
    assign bus.cs_slave  = r_cs_slave;
    assign bus.cs_nvram  = r_cs_nvram;
endmodule

// File: tb/tb_attex_bus_ctrl.sv
// Scoreboarded bench for attex_bus_ctrl: each access pushes its expected response
// (ack/err, data, latency in cycles from the strobe cycle) and the response pops it.
module tb_attex_bus_ctrl;
    import attex_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    attex_bus_ctrl_if bus();

    attex_bus_ctrl #(
        .CDIC_WAIT       (2),
        .NVRAM_WAIT      (1),
        .TIMEOUT_CYCLES  (15),
        .SLAVE_IRQ_DELAY (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          err;
        logic [15:0] dat;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   irq_q[$];
    int   t0;
    int   ts;
    logic [3:0] csv;
    logic [1:0] mon_v;

    assign csv = {bus.cs_mcd212, bus.cs_cdic, bus.cs_slave, bus.cs_nvram};

    localparam int NDEC = 13;
    logic [23:0] dec_a [NDEC] = '{24'h27FFFE, 24'h280000, 24'h3FFFFE, 24'h400000,
                                  24'h5FFFFE, 24'h600000, 24'hCFFFFE, 24'hD00000,
                                  24'hEFFFFE, 24'hF00000, 24'h300000, 24'h31FFFE,
                                  24'h320000};
    region_e     dec_r [NDEC] = '{REG_MCD, REG_NONE, REG_NONE, REG_MCD,
                                  REG_MCD, REG_ERR, REG_ERR, REG_NONE,
                                  REG_NONE, REG_ERR, REG_CDIC, REG_SLAVE,
                                  REG_NVRAM};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.slave_irq)
            irq_q.push_back(cyc);
        if (!reset) begin
            mon_v = {($countones(csv) > 1), bus.bus_ack & bus.bus_err};
            check("excl", 32'(mon_v), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start(input logic [23:0] a, input logic wr);
        bus.addr         = a[23:1];
        bus.write_strobe = wr;
        bus.as           = 1'b1;
        bus.uds          = 1'b1;
        bus.lds          = 1'b1;
        t0               = cyc;
    endtask

    task automatic stop();
        bus.as  = 1'b0;
        bus.uds = 1'b0;
        bus.lds = 1'b0;
    endtask

    task automatic expect_rsp(input bit err, input logic [15:0] dat, input int lat);
        exp_t e;
        e.err = err;
        e.dat = dat;
        e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic wait_rsp(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!(bus.bus_ack || bus.bus_err) && n < 300) begin
            tick();
            n++;
        end
        e = sb_q.pop_front();
        check({tag, "_err"}, 32'(bus.bus_err), 32'(e.err));
        check({tag, "_ack"}, 32'(bus.bus_ack), 32'(!e.err));
        check({tag, "_lat"}, 32'(cyc - t0), 32'(e.lat));
        if (!e.err)
            check({tag, "_dat"}, 32'(bus.data_in), 32'(e.dat));
    endtask

    initial begin
        stop();
        bus.addr           = '0;
        bus.write_strobe   = 1'b0;
        bus.mcd212_dout    = '0;
        bus.mcd212_bus_ack = 1'b0;
        bus.cdic_dout      = '0;
        bus.slave_dout     = '0;
        bus.dtackslaven    = 1'b0;
        bus.nvram_dout     = '0;
        reset              = 1'b1;
        repeat (3) tick();
        check("rst_cs", 32'(csv), 32'd0);
        check("rst_ack_err_irq", 32'({bus.bus_ack, bus.bus_err, bus.slave_irq}), 32'd0);
        check("rst_data", 32'(bus.data_in), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NDEC; i++)
            check($sformatf("dec_%h", dec_a[i]), 32'(decode_region(dec_a[i][23:1])), 32'(dec_r[i]));

        // CDIC read: cs on cycle 1, ack on cycle 3.
        bus.cdic_dout = 16'h1234;
        start(24'h300000, 1'b0);
        expect_rsp(1'b0, 16'h1234, 3);
        tick();
        check("cdic_cs", 32'(csv), 32'b0100);
        check("cdic_noack", 32'(bus.bus_ack), 32'd0);
        wait_rsp("cdic");
        stop();
        tick();
        check("cdic_clr", 32'({csv, bus.bus_ack, bus.bus_err}), 32'd0);

        // MCD read: device ack raised 5 cycles after cs.
        bus.mcd212_dout = 16'hBEEF;
        start(24'h000100, 1'b0);
        expect_rsp(1'b0, 16'hBEEF, 7);
        tick();
        check("mcd_cs", 32'(csv), 32'b1000);
        run_to(t0 + 6);
        bus.mcd212_bus_ack = 1'b1;
        wait_rsp("mcd");
        check("mcd_only", 32'(csv), 32'b1000);
        stop();
        bus.mcd212_bus_ack = 1'b0;
        tick();

        // NVRAM read: byte replicated on both lanes.
        bus.nvram_dout = 8'hA5;
        start(24'h320004, 1'b0);
        expect_rsp(1'b0, 16'hA5A5, 2);
        tick();
        check("nv_cs", 32'(csv), 32'b0001);
        wait_rsp("nv");
        stop();
        tick();

        // Slave write (data_in unchanged), then a slave read that restarts the irq delay.
        ts = cyc;
        start(24'h310002, 1'b1);
        expect_rsp(1'b0, 16'hA5A5, 8);
        tick();
        check("slv_cs", 32'(csv), 32'b0010);
        run_to(ts + 7);
        bus.dtackslaven = 1'b1;
        wait_rsp("slv_wr");
        stop();
        run_to(ts + 10);
        bus.slave_dout = 16'h5A5A;
        start(24'h310000, 1'b0);
        expect_rsp(1'b0, 16'h5A5A, 6);
        run_to(ts + 13);
        check("slv_held_hi_noack", 32'(bus.bus_ack), 32'd0);
        bus.dtackslaven = 1'b0;
        run_to(ts + 15);
        bus.dtackslaven = 1'b1;
        wait_rsp("slv_rd");
        stop();
        bus.dtackslaven = 1'b0;
        run_to(ts + 32);
        check("irq_count", 32'(irq_q.size()), 32'd1);
        check("irq_cycle", 32'((irq_q.size() > 0) ? irq_q[0] - ts : -1), 32'd30);

        // Forbidden region: bus_err on the next cycle, held while as stays high.
        start(24'h700000, 1'b0);
        expect_rsp(1'b1, 16'h0000, 1);
        wait_rsp("err");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_hold", 32'({bus.bus_err, bus.bus_ack, csv}), 32'b100000);
        end
        stop();
        tick();
        check("err_clr", 32'(bus.bus_err), 32'd0);

        // Unmapped read: bus_err after 15 WAIT cycles, never a select.
        start(24'h2A0000, 1'b0);
        expect_rsp(1'b1, 16'h0000, 16);
        tick();
        check("unmap_cs", 32'(csv), 32'd0);
        wait_rsp("unmap");
        stop();
        tick();

        // Reset during WAIT of an MCD cycle aborts it silently.
        start(24'h400000, 1'b0);
        tick();
        check("rmcd_cs", 32'(csv), 32'b1000);
        run_to(t0 + 3);
        reset = 1'b1;
        stop();
        tick();
        check("rmcd_abort", 32'({csv, bus.bus_ack, bus.bus_err, bus.slave_irq}), 32'd0);
        check("rmcd_data", 32'(bus.data_in), 32'd0);
        reset = 1'b0;
        bus.mcd212_bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rmcd_noack", 32'(bus.bus_ack), 32'd0);
        end
        bus.mcd212_bus_ack = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
